apb_master: RTL and testbench

- APB requester that drives the bus consumed by apb_slave in the UART-over-APB controller.
- Accepts single read/write commands on a valid/ready command port and sequences them through the APB IDLE/SETUP/ACCESS phases.
- Waits on PREADY, returns read data or a timeout error on a one-cycle response strobe, and supports back-to-back transfers.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_if.sv | 38 +++
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_master.sv | 124 ++++++++++++
 tb/tb_apb_master.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: phase state encoding and default bus widths.
// Also used by apb_slave, so the encoding must stay fixed.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB bus signals of the APB requester, bundled as one interface.
// Handshake: a command transfers on a PCLK edge where cmd_valid && cmd_ready; rsp_valid is a one-cycle strobe with no back-pressure.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS wait cycles; o_expired marks the edge on which the count reaches TIMEOUT.
// TIMEOUT = 0 disables expiry.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expiry is combinational so the abort happens on the edge that would make the count equal TIMEOUT.
  assign o_expired = (TIMEOUT > 0) && i_count_en && (r_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: single read/write commands sequenced through IDLE/SETUP/ACCESS with
// PREADY wait states, wait timeout abort, and a one-cycle registered response strobe.
module apb_master
  import apb_pkg::*;
#(
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_master_if.master bus,
  output apb_state_e   o_dbg_state
);

  apb_state_e    r_state, w_state_n;
  logic          r_psel, r_penable, r_pwrite, r_rsp_valid, r_rsp_err;
  logic [AW-1:0] r_paddr, w_paddr_n;
  logic [DW-1:0] r_pwdata, w_pwdata_n, r_rsp_rdata, w_rsp_rdata_n;
  logic          w_psel_n, w_penable_n, w_pwrite_n;
  logic          w_rsp_valid_n, w_rsp_err_n, w_cmd_ready;
  logic          w_tmr_en, w_expired;

  assign w_tmr_en = (r_state == ACCESS) && !bus.PREADY;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk        (PCLK),
    .rst        (PRESET),
    .i_clear    (!w_tmr_en),
    .i_count_en (w_tmr_en),
    .o_expired  (w_expired)
  );

  always_comb begin
    w_state_n     = r_state;
    w_pwrite_n    = r_pwrite;
    w_paddr_n     = r_paddr;
    w_pwdata_n    = r_pwdata;
    w_rsp_valid_n = 1'b0;
    w_rsp_err_n   = r_rsp_err;
    w_rsp_rdata_n = r_rsp_rdata;
    w_cmd_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_pwrite_n = bus.cmd_write;
          w_paddr_n  = bus.cmd_addr;
          w_pwdata_n = bus.cmd_wdata;
          w_state_n  = SETUP;
        end
      end
      SETUP: w_state_n = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          w_cmd_ready   = 1'b1;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = 1'b0;
          w_rsp_rdata_n = r_pwrite ? '0 : bus.PRDATA;
          // A waiting command is taken on the completion edge, keeping PSELx high.
          if (bus.cmd_valid) begin
            w_pwrite_n = bus.cmd_write;
            w_paddr_n  = bus.cmd_addr;
            w_pwdata_n = bus.cmd_wdata;
            w_state_n  = SETUP;
          end else begin
            w_state_n = IDLE;
          end
        end else if (w_expired) begin
          w_state_n     = IDLE;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = 1'b1;
          w_rsp_rdata_n = '0;
        end
      end
      default: begin
        w_state_n     = IDLE;
        w_pwrite_n    = 1'b0;
        w_paddr_n     = '0;
        w_pwdata_n    = '0;
        w_rsp_err_n   = 1'b0;
        w_rsp_rdata_n = '0;
      end
    endcase
    w_psel_n    = (w_state_n == SETUP) || (w_state_n == ACCESS);
    w_penable_n = (w_state_n == ACCESS);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_n;
      r_psel      <= w_psel_n;
      r_penable   <= w_penable_n;
      r_pwrite    <= w_pwrite_n;
      r_paddr     <= w_paddr_n;
      r_pwdata    <= w_pwdata_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_err   <= w_rsp_err_n;
      r_rsp_rdata <= w_rsp_rdata_n;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.PSELx     = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed commands, bench-side slave on PREADY/PRDATA,
// expected responses queued as {cycle, err, rdata} and popped by a negedge monitor.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TMO = 4;
  localparam int EW  = 49;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  apb_state_e dbg;

  apb_master_if #(.AW(32), .DW(32)) bus ();

  apb_master #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .PCLK        (clk),
    .PRESET      (rst),
    .bus         (bus),
    .o_dbg_state (dbg)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", bus.rsp_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp {cyc,err,rdata}", {cyc[15:0], bus.rsp_err, bus.rsp_rdata}, mon_e);
      end
    end
  end

  // Driver tasks; all start just after a rising edge
  task automatic wait_accept(output int t, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    t = cyc;
    chk("cmd_accept", ok, 1'b1);
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] prdata, input bit tmo);
    int   t;
    int   nacc;
    logic ok;
    logic rdy_exp;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.PREADY    = 1'b0;
    wait_accept(t, ok);
    bus.cmd_valid = 1'b0;
    if (ok) begin
      if (tmo) exp_q.push_back({16'(t + 1 + TMO), 1'b1, 32'h0});
      else     exp_q.push_back({16'(t + 2 + waits), 1'b0, (wr ? 32'h0 : prdata)});
      bus.PREADY = !tmo && (waits == 0);
      bus.PRDATA = prdata;
      @(negedge clk);
      chk("setup_psel", bus.PSELx, 1'b1);
      chk("setup_penable", bus.PENABLE, 1'b0);
      chk("setup_paddr", bus.PADDR, addr);
      chk("setup_pwrite", bus.PWRITE, wr);
      if (wr) chk("setup_pwdata", bus.PWDATA, wdata);
      nacc = tmo ? TMO : waits + 1;
      for (int i = 0; i < nacc; i++) begin
        @(posedge clk);
        #1;
        rdy_exp    = !tmo && (i == waits);
        bus.PREADY = rdy_exp;
        @(negedge clk);
        chk("access_psel", bus.PSELx, 1'b1);
        chk("access_penable", bus.PENABLE, 1'b1);
        chk("access_paddr", bus.PADDR, addr);
        chk("access_cmd_ready", bus.cmd_ready, rdy_exp);
      end
      @(posedge clk);
      #1;
      bus.PREADY = 1'b0;
      @(negedge clk);
      chk("done_psel", bus.PSELx, 1'b0);
      chk("done_penable", bus.PENABLE, 1'b0);
      chk("done_state", dbg, IDLE);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   t;
    logic ok;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", bus.PSELx, 1'b0);
    chk("rst_penable", bus.PENABLE, 1'b0);
    chk("rst_pwrite", bus.PWRITE, 1'b0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_state", dbg, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle hold
    repeat (10) begin
      @(negedge clk);
      chk("idle_psel", bus.PSELx, 1'b0);
      chk("idle_penable", bus.PENABLE, 1'b0);
      chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
      chk("idle_cmd_ready", bus.cmd_ready, 1'b1);
    end
    @(posedge clk);
    #1;

    run_cmd(1'b1, 32'h05, 32'h0000_ABCD, 0, 32'h0, 1'b0);
    run_cmd(1'b0, 32'h06, 32'h0, 3, 32'd917, 1'b0);

    // Back-to-back: write 0x07/0x11 then read 0x07 with cmd_valid held high
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h07;
    bus.cmd_wdata = 32'h11;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'd817;
    wait_accept(t, ok);
    exp_q.push_back({16'(t + 2), 1'b0, 32'h0});
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_s1_psel", bus.PSELx, 1'b1);
    chk("b2b_s1_penable", bus.PENABLE, 1'b0);
    chk("b2b_s1_cmd_ready", bus.cmd_ready, 1'b0);
    chk("b2b_s1_pwrite", bus.PWRITE, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b_a1_psel", bus.PSELx, 1'b1);
    chk("b2b_a1_penable", bus.PENABLE, 1'b1);
    chk("b2b_a1_pwdata", bus.PWDATA, 32'h11);
    chk("b2b_a1_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    exp_q.push_back({16'(t + 4), 1'b0, 32'd817});
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_s2_psel", bus.PSELx, 1'b1);
    chk("b2b_s2_penable", bus.PENABLE, 1'b0);
    chk("b2b_s2_pwrite", bus.PWRITE, 1'b0);
    chk("b2b_s2_paddr", bus.PADDR, 32'h07);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b_a2_psel", bus.PSELx, 1'b1);
    chk("b2b_a2_penable", bus.PENABLE, 1'b1);
    @(posedge clk);
    #1;
    bus.PREADY = 1'b0;
    @(negedge clk);
    chk("b2b_end_psel", bus.PSELx, 1'b0);
    chk("b2b_end_penable", bus.PENABLE, 1'b0);
    @(posedge clk);
    #1;

    // Timeout, then a normal read clears rsp_err
    run_cmd(1'b0, 32'h03, 32'h0, 0, 32'hDEAD_BEEF, 1'b1);
    run_cmd(1'b0, 32'h04, 32'h0, 0, 32'h0000_1234, 1'b0);

    // Asynchronous reset during ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h09;
    bus.PREADY    = 1'b0;
    wait_accept(t, ok);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_penable", bus.PENABLE, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_psel", bus.PSELx, 1'b0);
    chk("arst_penable", bus.PENABLE, 1'b0);
    chk("arst_paddr", bus.PADDR, 32'h0);
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_state", dbg, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("post_rst_psel", bus.PSELx, 1'b0);
    end
    @(posedge clk);
    #1;
    run_cmd(1'b1, 32'h0A, 32'h0000_5A5A, 1, 32'h0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
